// File: rtl/iq_fetch_ctrl.sv
// iq_fetch_ctrl: fetch sequencer for the ID-stage instruction queue.
// Owns the fetch PC and issues aligned 16-byte fetch requests. It tracks
// in-flight requests against free queue slots and discards stale responses
// after a flush or a predicted-taken redirect.
// Optional build macro: FETCH_CTRL_PERF_EN adds the stall-cycle and
// dropped-response saturating counters.
module iq_fetch_ctrl #(
  parameter int          IQ_DEPTH     = 16,
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [31:0]                  flush_pc_i,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic [31:0]                  req_pc_o,
  input  logic                         rsp_valid_i,
  input  logic [2:0]                   rsp_num_i,
  input  logic                         rsp_redirect_i,
  input  logic [31:0]                  rsp_target_i,
  input  logic [$clog2(IQ_DEPTH):0]    iq_count_i,
  output logic                         iq_wr_valid_o,
  output logic [2:0]                   iq_wr_num_o,
  output logic [1:0]                   inflight_o,
  output logic [1:0]                   state_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cyc_o,
  output logic [31:0]                  perf_drop_rsp_o
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Credit sum width leaves headroom so the sum can never wrap.
  localparam int SW = $clog2(IQ_DEPTH) + 3;

  logic [31:0]   pc_reg, pc_next;
  logic [1:0]    state_reg, state_next;
  logic [1:0]    inflight_reg, inflight_next;
  logic [1:0]    drop_cnt_reg, drop_next;
  logic [SW-1:0] credit_sum;
  logic          space_ok;
  logic          cap_ok;
  logic          req_fire;
  logic          rsp_drop;
  logic          redirect;
  logic [31:0]   pc_seq;

  // Credit check: always reserve a full 4 slots per outstanding request.
  always_comb begin
    credit_sum = SW'(iq_count_i) + SW'({inflight_reg, 2'b00}) + SW'(4);
    space_ok   = (credit_sum <= SW'(IQ_DEPTH));
    cap_ok     = (inflight_reg < 2'(MAX_INFLIGHT));
  end

  // Request, queue-write and event decode; everything is gated while in reset.
  always_comb begin
    req_valid_o   = rst && (state_reg == ST_RUN) && space_ok && cap_ok && !flush_i;
    req_pc_o      = pc_reg;
    req_fire      = req_valid_o && req_ready_i;
    rsp_drop      = rsp_valid_i && (drop_cnt_reg != 2'd0);
    iq_wr_valid_o = rst && rsp_valid_i && (drop_cnt_reg == 2'd0) && !flush_i;
    iq_wr_num_o   = iq_wr_valid_o ? rsp_num_i : 3'd0;
    redirect      = iq_wr_valid_o && rsp_redirect_i;
    pc_seq        = {pc_reg[31:4] + 28'd1, 4'b0000};
    inflight_next = inflight_reg + {1'b0, req_fire} - {1'b0, rsp_valid_i};
  end

  // Next PC, drop count and FSM state; flush outranks redirect, which outranks sequential flow.
  always_comb begin
    pc_next    = pc_reg;
    state_next = state_reg;
    drop_next  = drop_cnt_reg;
    if (rsp_drop) drop_next = drop_cnt_reg - 2'd1;
    if (req_fire) pc_next = pc_seq;
    case (state_reg)
      ST_RUN:   if (!space_ok) state_next = ST_STALL;
      ST_STALL: if (space_ok) state_next = ST_RUN;
      ST_DRAIN: if (drop_next == 2'd0) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
    if (flush_i) begin
      pc_next    = flush_pc_i;
      drop_next  = inflight_next;
      state_next = (inflight_next != 2'd0) ? ST_DRAIN : ST_RUN;
    end else if (redirect) begin
      pc_next    = rsp_target_i;
      drop_next  = inflight_next;
      state_next = (inflight_next != 2'd0) ? ST_DRAIN : ST_RUN;
    end
  end

  // State registers; reset abandons any outstanding requests outright.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      state_reg    <= ST_RUN;
      inflight_reg <= 2'd0;
      drop_cnt_reg <= 2'd0;
    end else begin
      pc_reg       <= pc_next;
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_next;
    end
  end

  assign inflight_o = inflight_reg;
  assign state_o    = state_reg;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cyc_reg;
  logic [31:0] drop_rsp_reg;

  // Saturating counters for STALL cycles and discarded responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cyc_reg <= 32'd0;
      drop_rsp_reg  <= 32'd0;
    end else begin
      if ((state_reg == ST_STALL) && (stall_cyc_reg != 32'hFFFF_FFFF))
        stall_cyc_reg <= stall_cyc_reg + 32'd1;
      if (rsp_drop && (drop_rsp_reg != 32'hFFFF_FFFF))
        drop_rsp_reg <= drop_rsp_reg + 32'd1;
    end
  end

  assign perf_stall_cyc_o = stall_cyc_reg;
  assign perf_drop_rsp_o  = drop_rsp_reg;
`endif

endmodule

// File: doc/iq_fetch_ctrl.md
# iq_fetch_ctrl

Fetch sequencer for the ID-stage instruction queue. It owns the fetch PC, issues aligned 16-byte fetch requests to the I-cache, and tracks in-flight requests against free queue slots so the queue never overflows. On a flush or a predicted-taken redirect it discards stale responses. It sits between the IF request port, the IF response path and the instruction queue's write port.

## Interface
Parameters:
- IQ_DEPTH, 16: instruction-queue capacity in instructions; power of two, at least 8.
- MAX_INFLIGHT, 2: maximum accepted-but-unanswered requests, 1..3.
- RESET_PC, 32'hBFC0_0000: fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush (SBA flush or CP0 exception).
- flush_pc_i  in  32  restart PC, valid with flush_i.
- req_valid_o  out  1  fetch request valid.
- req_ready_i  in  1  I-cache accepts the request.
- req_pc_o  out  32  fetch PC.
- rsp_valid_i  in  1  I-cache response, returned in order.
- rsp_num_i  in  3  instructions in the response, 1..4.
- rsp_redirect_i  in  1  response contains a predicted-taken branch.
- rsp_target_i  in  32  predicted target, valid with rsp_redirect_i.
- iq_count_i  in  $clog2(IQ_DEPTH)+1  current queue occupancy.
- iq_wr_valid_o  out  1  write the current response into the queue.
- iq_wr_num_o  out  3  instructions written, equal to rsp_num_i.
- inflight_o  out  2  current in-flight count.
- state_o  out  2  FSM state (RUN=0, STALL=1, DRAIN=2).

## Operation
- Fetch length is computed from the PC: len = 4 - pc[3:2]. The next sequential PC is {pc[31:4]+1, 4'b0}.
- Credit rule: a request may issue only when iq_count_i + 4*inflight + 4 <= IQ_DEPTH and inflight < MAX_INFLIGHT. The check is conservative and always reserves 4 slots per request.
- FSM states:
  - RUN: req_valid_o = 1 when the credit rule holds and flush_i = 0. If the credit rule fails, go to STALL.
  - STALL: req_valid_o = 0. Return to RUN in the cycle after the credit rule holds again.
  - DRAIN: entered on flush, or on a redirect while other requests are still in flight. req_valid_o = 0. Go to RUN when drop_cnt reaches 0.
- Request handshake (req_valid_o && req_ready_i):
  - inflight increments by 1.
  - pc advances to the next sequential PC.
- Response (rsp_valid_i):
  - inflight decrements by 1.
  - If drop_cnt > 0: drop_cnt decrements by 1 and iq_wr_valid_o = 0.
  - Otherwise: iq_wr_valid_o = 1 and iq_wr_num_o = rsp_num_i.
- Redirect (a non-dropped response with rsp_redirect_i = 1):
  - pc is set to rsp_target_i.
  - drop_cnt is set to the post-update inflight count.
  - Next state is DRAIN if drop_cnt > 0, otherwise RUN.
- Flush (flush_i = 1):
  - pc is set to flush_pc_i.
  - drop_cnt is set to the post-update inflight count.
  - Next state is DRAIN if drop_cnt > 0, otherwise RUN.
  - iq_wr_valid_o is forced to 0 in the flush cycle.
- Simultaneous events:
  - Flush outranks redirect and request; the request is not issued in the flush cycle.
  - A response and a request in the same cycle leave inflight unchanged.
  - A flush in the same cycle as a response counts that response as already consumed and does not add it to drop_cnt.
- Reset: all outputs and state are forced to their reset values regardless of other inputs. Mid-operation, this abandons any in-flight requests without counting them for dropping.

## Timing
- Reset values:
  - pc = RESET_PC, state = RUN, inflight = 0, drop_cnt = 0.
  - req_pc_o = RESET_PC, req_valid_o = 0 during reset, iq_wr_valid_o = 0, iq_wr_num_o = 0.
- req_valid_o and req_pc_o are combinational from registered state plus flush_i and iq_count_i. req_pc_o stays stable while req_valid_o is high and not accepted.
- iq_wr_valid_o and iq_wr_num_o are combinational from rsp_valid_i and drop_cnt, giving zero latency to the queue write. The queue count updates the next cycle.
- First request is presented in the first cycle after rst deasserts.
- Flush to the first new request takes 1 cycle when inflight is 0, or 1 cycle after the last stale response when draining.
- Width rules:
  - inflight and drop_cnt are 2 bits and never exceed MAX_INFLIGHT.
  - The credit sum is computed at $clog2(IQ_DEPTH)+3 bits with no wrap-around.
  - The pc increment wraps at 2^32.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds two 32-bit saturating counters.
  - perf_stall_cyc_o counts cycles spent in STALL.
  - perf_drop_rsp_o counts dropped responses.
  - Both reset to 0.
- FETCH_CTRL_PERF_EN undefined: these ports and counters are absent, with identical functional behaviour otherwise.

## Test plan
- Reset release, IQ_DEPTH=16, iq_count_i=0, req_ready_i=1 -> requests at RESET_PC, then 0xBFC0_0010. inflight reaches 2 and req_valid_o drops; state stays RUN because the cap is reached but credit holds.
- iq_count_i=9, inflight=0 -> one request is accepted (9+4 <= 16). Next cycle: 9+4+4 > 16 -> STALL and req_valid_o=0. iq_count_i falls to 8 -> RUN the next cycle.
- Start PC 0x1008 -> len 2. After acceptance req_pc_o = 0x1010.
- Two requests in flight, flush_i with flush_pc_i=0x8000_0180 -> DRAIN with drop_cnt=2. Both responses give iq_wr_valid_o=0. Then RUN with req_pc_o=0x8000_0180.
- Response with rsp_redirect_i=1 and target 0x2040 while one other request is in flight -> that response is written. DRAIN drops exactly one response, then a request at 0x2040.
- Flush, response and req_ready_i all in the same cycle with inflight=1 -> no request is accepted, drop_cnt=0, next state RUN, iq_wr_valid_o=0.
